// File: rtl/awgn_pkg.sv
// rtl/awgn_pkg.sv - shared Q-format and config constants for the AWGN noise scheduler
package awgn_pkg;

    localparam int FRAC_W   = 7;
    localparam int SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic {
        CFG_STD  = 1'b0,
        CFG_MEAN = 1'b1
    } cfg_sel_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_next_ptr
);

    always_comb begin
        o_any      = 1'b0;
        o_idx      = '0;
        o_grant    = '0;
        o_next_ptr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[c]) begin
                o_any = 1'b1;
                o_idx = IDX_W'(c);
            end
        end
        if (o_any) begin
            o_grant = NUM_REQ'(1) << o_idx;
        end
        o_next_ptr = (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/awgn_noise_scheduler.sv
// rtl/awgn_noise_scheduler.sv - round-robin sharing of one N(0,1) stream with per-requester STD/MEAN scaling
module awgn_noise_scheduler
    import awgn_pkg::*;
#(
    parameter int                 NUM_REQ  = 4,
    parameter int                 IDX_W    = 2,
    parameter logic signed [15:0] STD_RST  = 16'sd128,
    parameter logic signed [15:0] MEAN_RST = 16'sd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] gaussian_normal_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         grant_o,
    input  logic                       cfg_we_i,
    input  logic                       cfg_sel_i,
    input  logic [IDX_W-1:0]           cfg_idx_i,
    input  logic signed [SAMPLE_W-1:0] cfg_data_i,
    output logic signed [SAMPLE_W-1:0] noise_o,
    output logic [IDX_W-1:0]           noise_id_o,
    output logic                       noise_valid_o,
    output logic                       sat_o
);

    logic signed [SAMPLE_W-1:0] r_std  [NUM_REQ];
    logic signed [SAMPLE_W-1:0] r_mean [NUM_REQ];

    logic [IDX_W-1:0]           r_ptr;
    logic [IDX_W-1:0]           r_gnt_idx;
    logic                       r_gnt_vld;

    logic signed [31:0]         r_prod;
    logic signed [SAMPLE_W-1:0] r_s1_mean;
    logic [IDX_W-1:0]           r_s1_id;
    logic                       r_s1_vld;

    logic [NUM_REQ-1:0]         w_gnt;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_any;
    logic [IDX_W-1:0]           w_next_ptr;

    logic signed [31:0]         w_g_ext;
    logic signed [31:0]         w_std_ext;
    logic signed [31:0]         w_shift;
    logic signed [32:0]         w_sum;
    logic                       w_clip;
    logic signed [SAMPLE_W-1:0] w_noise;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req      (req_i),
        .i_ptr      (r_ptr),
        .o_grant    (w_gnt),
        .o_idx      (w_idx),
        .o_any      (w_any),
        .o_next_ptr (w_next_ptr)
    );

    // Capture reads the register file before this cycle's config write lands.
    assign w_g_ext   = {{16{gaussian_normal_i[15]}}, gaussian_normal_i};
    assign w_std_ext = {{16{r_std[r_gnt_idx][15]}}, r_std[r_gnt_idx]};

    assign w_shift = r_prod >>> FRAC_W;
    assign w_sum   = {w_shift[31], w_shift} + {{17{r_s1_mean[15]}}, r_s1_mean};
    assign w_clip  = !((&w_sum[32:15]) || !(|w_sum[32:15]));
    assign w_noise = w_clip ? (w_sum[32] ? SAT_MIN : SAT_MAX) : w_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_o       <= '0;
            r_ptr         <= '0;
            r_gnt_idx     <= '0;
            r_gnt_vld     <= 1'b0;
            r_prod        <= '0;
            r_s1_mean     <= '0;
            r_s1_id       <= '0;
            r_s1_vld      <= 1'b0;
            noise_o       <= '0;
            noise_id_o    <= '0;
            noise_valid_o <= 1'b0;
            sat_o         <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_std[k]  <= STD_RST;
                r_mean[k] <= MEAN_RST;
            end
        end else begin
            if (en_i && w_any) begin
                grant_o   <= w_gnt;
                r_gnt_idx <= w_idx;
                r_gnt_vld <= 1'b1;
                r_ptr     <= w_next_ptr;
            end else begin
                grant_o   <= '0;
                r_gnt_vld <= 1'b0;
            end

            r_prod    <= w_g_ext * w_std_ext;
            r_s1_mean <= r_mean[r_gnt_idx];
            r_s1_id   <= r_gnt_idx;
            r_s1_vld  <= r_gnt_vld;

            noise_valid_o <= r_s1_vld;
            if (r_s1_vld) begin
                noise_o    <= w_noise;
                noise_id_o <= r_s1_id;
                sat_o      <= w_clip;
            end

            for (int k = 0; k < NUM_REQ; k++) begin
                if (cfg_we_i && cfg_idx_i == IDX_W'(k)) begin
                    if (cfg_sel_i == CFG_STD) begin
                        r_std[k] <= cfg_data_i;
                    end else begin
                        r_mean[k] <= cfg_data_i;
                    end
                end
            end
        end
    end

endmodule
